imem_multiport: RTL and testbench
=================================

# imem_multiport

Parametrised multi-core instruction memory. It serves NUM_CORES independent single-cycle read ports from one shared instruction RAM, and adds a streaming program-load port so the RAM is filled at run time instead of being fixed at elaboration. It sits between the program loader (host/UART front end) and the per-core fetch stages of the processor array. A core fetches only after a complete program has been loaded.

## Interface
Parameters:
- NUM_CORES, 16, number of read ports
- ADDR_W, 16, address width per port
- DATA_W, 16, instruction width
- DEPTH, 64, RAM words; power of two, DEPTH ≤ 2^ADDR_W

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- Control  in  2*NUM_CORES  per-core command; core i at [2i+1:2i]; 2'd1 = read, others = idle
- InstrAddr  in  ADDR_W*NUM_CORES  per-core read address, core i at [ADDR_W*i +: ADDR_W]
- InstrOut  out  DATA_W*NUM_CORES  per-core instruction, registered
- InstrValid  out  NUM_CORES  per-core one-cycle strobe: InstrOut updated by a read this cycle
- load_start  in  1  pulse: begin a new program load at word 0
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  program word
- load_last  in  1  qualifies final word of the program
- load_ready  out  1  loader accepts a word this cycle
- prog_ready  out  1  a complete program is resident; reads are serviced
- load_count  out  clog2(DEPTH)+1  words written in the current/last load
- AddrErr  out  NUM_CORES  sticky per-core out-of-range flag (only with IMEM_RANGE_CHECK_EN)

## Operation
- Loader FSM has three states: EMPTY (reset state), LOAD, READY.
- EMPTY → LOAD on load_start.
- LOAD: load_ready = 1 while wptr < DEPTH. A word is accepted when load_valid && load_ready: ram[wptr] ← load_data, then wptr and load_count increment.
- LOAD → READY when an accepted word carries load_last, or when the accepted word is the one at wptr = DEPTH-1.
- load_start in LOAD restarts the load: wptr = 0, load_count = 0. Any word presented in that cycle is discarded.
- READY → LOAD on load_start. prog_ready drops in the same edge.
- load_start has priority over load_valid in every state.
- prog_ready = (state == READY).
- Read port i, in READY with Control_i == 2'd1: InstrOut_i ← ram[InstrAddr_i] and InstrValid_i = 1 on the next cycle.
- Otherwise InstrOut_i holds its value and InstrValid_i = 0. This includes reads issued in EMPTY or LOAD, which are dropped and not queued.
- All ports read in the same cycle with no arbitration. Identical addresses on several ports are legal.
- RAM contents are not reset. Words beyond load_count keep stale data.

## Timing
- Reset values:
  - InstrOut = 0, InstrValid = 0, load_ready = 0
  - prog_ready = 0, load_count = 0, AddrErr = 0
  - state = EMPTY, wptr = 0
- Read latency is 1 cycle: Control/InstrAddr sampled at edge k; InstrOut/InstrValid valid after edge k.
- Throughput is one read per port per cycle.
- load_ready is registered from state and wptr. It rises the cycle after load_start and drops the cycle after the final accept.
- The first read is serviced in the cycle after the one in which prog_ready is first seen high. A read issued in the same cycle as the final load accept is dropped.
- Reset asserted mid-load: immediate return to EMPTY. The partial program is discarded logically (prog_ready = 0); RAM words are not cleared.

## Configuration
- IMEM_RANGE_CHECK_EN defined:
  - A read with InstrAddr_i ≥ DEPTH returns DATA_W'h1000 (END opcode, 0001 in [15:12]) with InstrValid_i = 1.
  - It sets AddrErr_i, which stays set until reset.
- IMEM_RANGE_CHECK_EN undefined:
  - The address is truncated to its low clog2(DEPTH) bits.
  - AddrErr is tied to 0.

## Test plan
- Reset, then reads on all ports with no load → InstrValid = 0, InstrOut = 0, prog_ready = 0.
- Load 62 words (0x2000+n) with load_last on word 61; all 16 ports read addresses 0..15 in one cycle → next cycle InstrOut_i = 0x2000+i, all InstrValid = 1, load_count = 62.
- Load DEPTH words without load_last → auto READY after word 63, load_ready low, load_count = 64. Extra load_valid words are ignored.
- load_start mid-load after 10 words, then 3 words with load_last → ram[0..2] hold the new data, load_count = 3. Reads during LOAD show InstrValid = 0.
- Reset asserted asynchronously mid-load → prog_ready, load_ready and InstrValid drop without a clock edge; a subsequent read is dropped until a reload completes.
- With IMEM_RANGE_CHECK_EN, port 3 reads address 100 → InstrOut_3 = 0x1000 and AddrErr[3] set and sticky. Without the macro → returns ram[36], AddrErr = 0.

Source files
------------

// File: rtl/imem_multiport.sv
// Multi-port instruction memory: NUM_CORES single-cycle read ports over one RAM
// that is filled at run time by a streaming loader. Optional macro: IMEM_RANGE_CHECK_EN.
module imem_multiport #(
  parameter int NUM_CORES = 16,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [2*NUM_CORES-1:0]        Control,
  input  logic [ADDR_W*NUM_CORES-1:0]   InstrAddr,
  output logic [DATA_W*NUM_CORES-1:0]   InstrOut,
  output logic [NUM_CORES-1:0]          InstrValid,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic                          prog_ready,
  output logic [$clog2(DEPTH):0]        load_count,
  output logic [NUM_CORES-1:0]          AddrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     wptr_r;
  logic              load_ready_r;
  logic              prog_ready_r;
  logic [DATA_W-1:0] ram_r [DEPTH];
  logic              accept_s;
  logic              final_s;

  // Word acceptance; a load_start in the same cycle discards the word
  always_comb begin
    accept_s = 1'b0;
    final_s  = 1'b0;
    if (state_r == ST_LOAD && load_valid && load_ready_r && !load_start) begin
      accept_s = 1'b1;
      final_s  = load_last || (wptr_r == CW'(DEPTH - 1));
    end else begin
      accept_s = 1'b0;
      final_s  = 1'b0;
    end
  end

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_EMPTY;
      wptr_r       <= '0;
      load_ready_r <= 1'b0;
      prog_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (load_start) begin
            state_r      <= ST_LOAD;
            wptr_r       <= '0;
            load_ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            wptr_r       <= '0;
            load_ready_r <= 1'b1;
          end else if (accept_s) begin
            wptr_r <= wptr_r + CW'(1);
            if (final_s) begin
              state_r      <= ST_READY;
              load_ready_r <= 1'b0;
              prog_ready_r <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (load_start) begin
            state_r      <= ST_LOAD;
            wptr_r       <= '0;
            load_ready_r <= 1'b1;
            prog_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_EMPTY;
          wptr_r       <= '0;
          load_ready_r <= 1'b0;
          prog_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Program RAM write port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (accept_s) begin
      ram_r[wptr_r[AW-1:0]] <= load_data;
    end
  end

  assign load_ready = load_ready_r;
  assign prog_ready = prog_ready_r;
  assign load_count = wptr_r;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_port
    logic [ADDR_W-1:0] addr_s;
    logic              rd_s;
    logic [DATA_W-1:0] out_r;
    logic              valid_r;

    assign addr_s = InstrAddr[ADDR_W*i +: ADDR_W];
    assign rd_s   = prog_ready_r && (Control[2*i +: 2] == 2'd1);

`ifdef IMEM_RANGE_CHECK_EN
    logic oor_s;
    logic err_r;

    assign oor_s = ({1'b0, addr_s} >= (ADDR_W + 1)'(DEPTH));

    // Read port with END-opcode substitution and sticky range error
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        out_r   <= '0;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
      end else if (rd_s) begin
        valid_r <= 1'b1;
        if (oor_s) begin
          out_r <= DATA_W'(16'h1000);
          err_r <= 1'b1;
        end else begin
          out_r <= ram_r[addr_s[AW-1:0]];
        end
      end else begin
        valid_r <= 1'b0;
      end
    end

    assign AddrErr[i] = err_r;
`else
    // Read port; out-of-range addresses wrap onto the RAM
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        out_r   <= '0;
        valid_r <= 1'b0;
      end else if (rd_s) begin
        valid_r <= 1'b1;
        out_r   <= ram_r[addr_s[AW-1:0]];
      end else begin
        valid_r <= 1'b0;
      end
    end
`endif

    assign InstrOut[DATA_W*i +: DATA_W] = out_r;
    assign InstrValid[i]                = valid_r;
  end

`ifndef IMEM_RANGE_CHECK_EN
  logic unused_addr_s;

  assign AddrErr       = '0;
  assign unused_addr_s = ^InstrAddr;
`endif

endmodule

// File: tb/tb_imem_multiport.sv
// Randomized bench for imem_multiport against a word-level behavioural model
// of the loader and read ports.
module tb_imem_multiport;

  localparam int NC    = 16;
  localparam int AWT   = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int CW    = 7;
`ifdef IMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [2*NC-1:0]   Control = '0;
  logic [AWT*NC-1:0] InstrAddr = '0;
  logic [DW*NC-1:0]  InstrOut;
  logic [NC-1:0]     InstrValid;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [DW-1:0]     load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              prog_ready;
  logic [CW-1:0]     load_count;
  logic [NC-1:0]     AddrErr;

  imem_multiport #(.NUM_CORES(NC), .ADDR_W(AWT), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .Control(Control), .InstrAddr(InstrAddr),
    .InstrOut(InstrOut), .InstrValid(InstrValid), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .prog_ready(prog_ready), .load_count(load_count),
    .AddrErr(AddrErr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model: 0 = no program, 1 = loading, 2 = program resident
  int            mode_m;
  int            wcnt_m;
  logic [15:0]   ram_m [DEPTH];
  bit            known_m [DEPTH];
  logic [15:0]   eo [NC];
  bit            ek [NC];
  bit            ev [NC];
  logic [NC-1:0] aerr_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode_m = 0;
    wcnt_m = 0;
    aerr_m = '0;
    for (int p = 0; p < NC; p++) begin
      eo[p] = 16'h0000;
      ek[p] = 1'b1;
      ev[p] = 1'b0;
    end
  endtask

  // Predict one clock edge from the current inputs, advance, then compare
  task automatic cycle();
    for (int p = 0; p < NC; p++) begin
      int a;
      a = int'(InstrAddr[AWT*p +: AWT]);
      if (mode_m == 2 && Control[2*p +: 2] == 2'd1) begin
        ev[p] = 1'b1;
        if (RANGE_CHK && a >= DEPTH) begin
          eo[p] = 16'h1000;
          ek[p] = 1'b1;
          aerr_m[p] = 1'b1;
        end else begin
          eo[p] = ram_m[a % DEPTH];
          ek[p] = known_m[a % DEPTH];
        end
      end else begin
        ev[p] = 1'b0;
      end
    end
    if (load_start) begin
      mode_m = 1;
      wcnt_m = 0;
    end else if (mode_m == 1 && load_valid) begin
      ram_m[wcnt_m]   = load_data;
      known_m[wcnt_m] = 1'b1;
      wcnt_m++;
      if (load_last || wcnt_m == DEPTH) mode_m = 2;
    end
    @(posedge clock);
    #1;
    for (int p = 0; p < NC; p++) begin
      check($sformatf("valid[%0d]", p), 64'(InstrValid[p]), 64'(ev[p]));
      if (ek[p]) check($sformatf("data[%0d]", p), 64'(InstrOut[DW*p +: DW]), 64'(eo[p]));
    end
    check("prog_ready", 64'(prog_ready), 64'(mode_m == 2));
    check("load_ready", 64'(load_ready), 64'(mode_m == 1));
    check("load_count", 64'(load_count), 64'(wcnt_m));
    check("addr_err", 64'(AddrErr), 64'(aerr_m));
  endtask

  task automatic rand_reads();
    for (int p = 0; p < NC; p++) begin
      Control[2*p +: 2]     = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
      InstrAddr[AWT*p +: AWT] = 16'($urandom_range(0, 127));
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    load_valid = 1'($urandom_range(0, 1));
    load_data  = 16'($urandom_range(0, 65535));
    rand_reads();
    cycle();
    load_start = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit use_last, input bit rnd, input logic [15:0] base);
    int guard;
    guard = 0;
    while (mode_m == 1 && wcnt_m < n && guard < 2000) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = rnd ? 16'($urandom_range(0, 65535)) : base + 16'(wcnt_m);
      load_last  = use_last && (wcnt_m == n - 1);
      rand_reads();
      cycle();
      guard++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL load_guard: got %0d words expected %0d", wcnt_m, n);
    end
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("arst_prog_ready", 64'(prog_ready), 64'd0);
    check("arst_load_ready", 64'(load_ready), 64'd0);
    check("arst_valid", 64'(InstrValid), 64'd0);
    check("arst_load_count", 64'(load_count), 64'd0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known_m[i] = 1'b0;
      ram_m[i]   = 16'h0000;
    end
    model_reset();
    rand_reads();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out", 64'(InstrOut[63:0]), 64'd0);
    check("rst_valid", 64'(InstrValid), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_prog_ready", 64'(prog_ready), 64'd0);
    check("rst_load_count", 64'(load_count), 64'd0);
    check("rst_addr_err", 64'(AddrErr), 64'd0);
    reset_n = 1'b1;

    // reads with no program are dropped
    for (int k = 0; k < 5; k++) begin
      rand_reads();
      load_valid = 1'($urandom_range(0, 1));
      cycle();
    end
    load_valid = 1'b0;

    // 62-word program terminated by load_last, then all ports read 0..15
    start_load();
    load_prog(62, 1'b1, 1'b0, 16'h2000);
    for (int p = 0; p < NC; p++) begin
      Control[2*p +: 2]       = 2'd1;
      InstrAddr[AWT*p +: AWT] = 16'(p);
    end
    cycle();
    for (int p = 0; p < NC; p++) begin
      check($sformatf("dir_rd[%0d]", p), 64'(InstrOut[DW*p +: DW]), 64'(16'h2000 + p));
    end
    check("dir_count62", 64'(load_count), 64'd62);
    for (int k = 0; k < 20; k++) begin
      rand_reads();
      cycle();
    end

    // full-depth load without load_last, extra words ignored
    start_load();
    load_prog(64, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = 16'($urandom_range(0, 65535));
      rand_reads();
      cycle();
    end
    load_valid = 1'b0;
    check("full_count64", 64'(load_count), 64'd64);
    check("full_ready_low", 64'(load_ready), 64'd0);

    // restart mid-load: the word presented with load_start is discarded
    start_load();
    load_prog(10, 1'b0, 1'b1, 16'h0000);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hdead;
    rand_reads();
    cycle();
    load_start = 1'b0;
    load_prog(3, 1'b1, 1'b1, 16'h0000);
    for (int p = 0; p < NC; p++) begin
      Control[2*p +: 2]       = 2'd1;
      InstrAddr[AWT*p +: AWT] = 16'(p);
    end
    cycle();
    check("restart_count3", 64'(load_count), 64'd3);

    // port 3 reads beyond the RAM
    Control = '0;
    Control[7:6] = 2'd1;
    InstrAddr[63:48] = 16'd100;
    cycle();
    Control = '0;
    cycle();
    cycle();
    if (RANGE_CHK) begin
      check("oor_data", 64'(InstrOut[63:48]), 64'h1000);
      check("oor_sticky", 64'(AddrErr[3]), 64'd1);
    end else begin
      check("wrap_data", 64'(InstrOut[63:48]), 64'(ram_m[36]));
      check("wrap_no_err", 64'(AddrErr), 64'd0);
    end

    // asynchronous reset while serving reads, then while loading
    for (int p = 0; p < NC; p++) begin
      Control[2*p +: 2]       = 2'd1;
      InstrAddr[AWT*p +: AWT] = 16'($urandom_range(0, 63));
    end
    cycle();
    async_reset();
    for (int k = 0; k < 4; k++) begin
      rand_reads();
      cycle();
    end
    start_load();
    load_prog(4, 1'b0, 1'b1, 16'h0000);
    async_reset();
    start_load();
    load_prog(8, 1'b1, 1'b1, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      rand_reads();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
